door_motor_sequencer: RTL and testbench

- Sequences the door drive motor for the door controller subsystem.
- Accepts up/down/stop commands and the end-of-travel sensors and light barrier, and drives the two motor direction outputs and the warning lamp.
- Enforces a dead time on every direction reversal, a travel watchdog and auto-close, so the motor bridge is never shorted and never left running.

---
 rtl/door_motor_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_door_motor_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/door_motor_sequencer.sv
// Door drive motor sequencer: direction control with reversal dead time,
// travel watchdog, auto-close and warning lamp, all outputs registered.
module door_motor_sequencer #(
  parameter int DEADTIME_CYC   = 4,
  parameter int TRAVEL_MAX_CYC = 64,
  parameter int AUTOCLOSE_CYC  = 32,
  parameter int FLASH_HALF     = 2,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_up,
  input  logic       cmd_down,
  input  logic       cmd_stop,
  input  logic       fault_clr,
  input  logic       sensortop,
  input  logic       sensorbottom,
  input  logic       lightbarrier,
  output logic       motorleft,
  output logic       motorright,
  output logic       lightsteady,
  output logic       lightflash,
  output logic       fault,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_UNKNOWN  = 3'd0,
    ST_OPENED   = 3'd1,
    ST_CLOSED   = 3'd2,
    ST_OPENING  = 3'd3,
    ST_CLOSING  = 3'd4,
    ST_STOPPED  = 3'd5,
    ST_DEADTIME = 3'd6,
    ST_FAULT    = 3'd7
  } state_t;

  // Each limit is compared against the count value seen in the last cycle of
  // the interval, so a state lasts exactly LIMIT cycles.
  localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEADTIME_CYC - 1);
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_MAX_CYC - 1);
  localparam logic [CNT_W-1:0] AUTO_LAST   = CNT_W'((AUTOCLOSE_CYC > 0) ? AUTOCLOSE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             pend_open;
  logic             pend_open_next;
  logic [CNT_W-1:0] flash_cnt;
  logic             sensor_conflict;
  logic             travel_over;
  logic             state_change;
  logic             flash_next_on;

  assign sensor_conflict = sensortop & sensorbottom;
  assign travel_over     = ((state == ST_OPENING) || (state == ST_CLOSING)) &&
                           (cnt >= TRAVEL_LAST);
  assign state_change    = (state_next != state);
  assign flash_next_on   = (state_next == ST_DEADTIME) || (state_next == ST_FAULT);
  assign state_o         = state;

  always_comb begin
    state_next     = state;
    pend_open_next = pend_open;
    cnt_clr        = 1'b0;
    if (sensor_conflict || travel_over) begin
      state_next = ST_FAULT;
    end else begin
      case (state)
        ST_UNKNOWN: begin
          if (cmd_stop)                        state_next = ST_UNKNOWN;
          else if (sensortop)                  state_next = ST_OPENED;
          else if (sensorbottom)               state_next = ST_CLOSED;
          else if (cmd_up)                     state_next = ST_OPENING;
          else if (cmd_down && !lightbarrier)  state_next = ST_CLOSING;
        end
        ST_OPENED: begin
          // Any activity at the door restarts the auto-close idle count.
          if (cmd_stop || cmd_up || lightbarrier) cnt_clr    = 1'b1;
          else if (cmd_down)                      state_next = ST_CLOSING;
          else if ((AUTOCLOSE_CYC != 0) && (cnt >= AUTO_LAST))
            state_next = ST_CLOSING;
        end
        ST_CLOSED: begin
          if (!cmd_stop && cmd_up) state_next = ST_OPENING;
        end
        ST_OPENING: begin
          if (cmd_stop)                  state_next = ST_STOPPED;
          else if (sensortop)            state_next = ST_OPENED;
          else if (cmd_down && !cmd_up) begin
            state_next     = ST_DEADTIME;
            pend_open_next = 1'b0;
          end
        end
        ST_CLOSING: begin
          if (cmd_stop) begin
            state_next = ST_STOPPED;
          end else if (lightbarrier) begin
            state_next     = ST_DEADTIME;
            pend_open_next = 1'b1;
          end else if (sensorbottom) begin
            state_next = ST_CLOSED;
          end else if (cmd_up) begin
            state_next     = ST_DEADTIME;
            pend_open_next = 1'b1;
          end
        end
        ST_STOPPED: begin
          if (cmd_stop)                        state_next = ST_STOPPED;
          else if (cmd_up)                     state_next = ST_OPENING;
          else if (cmd_down && !lightbarrier)  state_next = ST_CLOSING;
        end
        ST_DEADTIME: begin
          // An opposite request re-targets the reversal and restarts the wait.
          if (cmd_stop) begin
            state_next = ST_STOPPED;
          end else if ((cmd_up || lightbarrier) && !pend_open) begin
            pend_open_next = 1'b1;
            cnt_clr        = 1'b1;
          end else if (cmd_down && !cmd_up && !lightbarrier && pend_open) begin
            pend_open_next = 1'b0;
            cnt_clr        = 1'b1;
          end else if (cnt >= DEAD_LAST) begin
            state_next = pend_open ? ST_OPENING : ST_CLOSING;
          end
        end
        ST_FAULT: begin
          if (fault_clr) state_next = ST_UNKNOWN;
        end
        default: state_next = ST_UNKNOWN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_UNKNOWN;
      pend_open <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_next;
      pend_open <= pend_open_next;
      if (state_change || cnt_clr) cnt <= '0;
      else if (cnt != CNT_MAX)     cnt <= cnt + 1'b1;
    end
  end

  // Lamp flash phase restarts at 1 on entry and keeps running through a
  // dead-time restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      lightflash <= 1'b0;
      flash_cnt  <= '0;
    end else if (!flash_next_on) begin
      lightflash <= 1'b0;
      flash_cnt  <= '0;
    end else if (state_change) begin
      lightflash <= 1'b1;
      flash_cnt  <= '0;
    end else if (flash_cnt >= FLASH_LAST) begin
      lightflash <= ~lightflash;
      flash_cnt  <= '0;
    end else begin
      flash_cnt <= flash_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      motorleft   <= 1'b0;
      motorright  <= 1'b0;
      lightsteady <= 1'b0;
      fault       <= 1'b0;
    end else begin
      motorleft   <= (state_next == ST_OPENING);
      motorright  <= (state_next == ST_CLOSING);
      lightsteady <= (state_next == ST_OPENING) || (state_next == ST_CLOSING);
      fault       <= (state_next == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_door_motor_sequencer.sv
// Bench for door_motor_sequencer: scenario tasks push the expected output
// vector {state_o, motorleft, motorright, lightsteady, lightflash, fault}.
module tb_door_motor_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_up, cmd_down, cmd_stop, fault_clr;
  logic       sensortop, sensorbottom, lightbarrier;
  logic       motorleft, motorright, lightsteady, lightflash, fault;
  logic [2:0] state_o;
  logic [7:0] obs;

  logic [7:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;

  localparam logic [7:0] O_UNK     = 8'b000_00000;
  localparam logic [7:0] O_OPENED  = 8'b001_00000;
  localparam logic [7:0] O_CLOSED  = 8'b010_00000;
  localparam logic [7:0] O_OPENING = 8'b011_10100;
  localparam logic [7:0] O_CLOSING = 8'b100_01100;
  localparam logic [7:0] O_STOPPED = 8'b101_00000;
  localparam logic [7:0] O_DT1     = 8'b110_00010;
  localparam logic [7:0] O_DT0     = 8'b110_00000;
  localparam logic [7:0] O_FLT1    = 8'b111_00011;
  localparam logic [7:0] O_FLT0    = 8'b111_00001;

  always #5 clk = ~clk;

  assign obs = {state_o, motorleft, motorright, lightsteady, lightflash, fault};

  door_motor_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_up       (cmd_up),
    .cmd_down     (cmd_down),
    .cmd_stop     (cmd_stop),
    .fault_clr    (fault_clr),
    .sensortop    (sensortop),
    .sensorbottom (sensorbottom),
    .lightbarrier (lightbarrier),
    .motorleft    (motorleft),
    .motorright   (motorright),
    .lightsteady  (lightsteady),
    .lightflash   (lightflash),
    .fault        (fault),
    .state_o      (state_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst = 1'b1; cmd_up = 1'b0; cmd_down = 1'b0; cmd_stop = 1'b0; fault_clr = 1'b0;
    sensortop = 1'b1; sensorbottom = 1'b0; lightbarrier = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rst = 1'b0;
      exp_q.push_back(i < 2 ? O_UNK : O_OPENED);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_close_run();
    logic [7:0] e;
    sensortop = 1'b0; cmd_down = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 1) cmd_down = 1'b0;
      if (i == 10) sensorbottom = 1'b1;
      exp_q.push_back(i < 10 ? O_CLOSING : O_CLOSED);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL close_run[%0d]: got %b expected %b", i, obs, e);
      end
    end
  endtask

  // Opening reversed by cmd_down, then closing reversed by the light barrier.
  task automatic test_obstacle();
    logic [7:0] e;
    logic [7:0] tab [11];
    tab = '{O_OPENING, O_DT1, O_DT1, O_DT0, O_DT0, O_CLOSING,
            O_DT1, O_DT1, O_DT0, O_DT0, O_OPENING};
    for (int i = 0; i < 11; i++) begin
      case (i)
        0: begin sensorbottom = 1'b0; cmd_up = 1'b1; end
        1: begin cmd_up = 1'b0; cmd_down = 1'b1; end
        2: cmd_down = 1'b0;
        6: lightbarrier = 1'b1;
        7: lightbarrier = 1'b0;
        default: ;
      endcase
      exp_q.push_back(tab[i]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL obstacle[%0d]: got %b expected %b", i, obs, e);
      end
    end
  endtask

  // Opening was entered on the previous edge; 63 more travel cycles then FAULT.
  task automatic test_watchdog();
    logic [7:0] e;
    for (int i = 0; i < 69; i++) begin
      if (i == 67) begin fault_clr = 1'b1; sensortop = 1'b1; end
      if (i == 68) fault_clr = 1'b0;
      if (i < 63)       e = O_OPENING;
      else if (i < 65)  e = O_FLT1;
      else if (i < 67)  e = O_FLT0;
      else if (i == 67) e = O_UNK;
      else              e = O_OPENED;
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL watchdog[%0d]: got %b expected %b", i, obs, e);
      end
    end
  endtask

  // OPENED was entered on the previous edge (idle index 0).
  task automatic test_autoclose();
    logic [7:0] e;
    for (int i = 1; i < 36; i++) begin
      case (i)
        33: begin sensortop = 1'b0; sensorbottom = 1'b1; end
        34: begin sensorbottom = 1'b0; cmd_up = 1'b1; end
        35: begin cmd_up = 1'b0; sensortop = 1'b1; end
        default: ;
      endcase
      if (i < 32)       e = O_OPENED;
      else if (i == 32) e = O_CLOSING;
      else if (i == 33) e = O_CLOSED;
      else if (i == 34) e = O_OPENING;
      else              e = O_OPENED;
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL autoclose[%0d]: got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_autoclose_barrier();
    logic [7:0] e;
    for (int i = 1; i < 53; i++) begin
      lightbarrier = (i == 20);
      exp_q.push_back(i < 52 ? O_OPENED : O_CLOSING);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL autoclose_barrier[%0d]: got %b expected %b", i, obs, e);
      end
    end
    lightbarrier = 1'b0;
  endtask

  // Closing with sensortop already 1; sensorbottom joins to make a conflict.
  task automatic test_conflict();
    logic [7:0] e;
    logic [7:0] tab [4];
    tab = '{O_FLT1, O_FLT1, O_UNK, O_OPENED};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: sensorbottom = 1'b1;
        1: fault_clr = 1'b1;
        2: sensorbottom = 1'b0;
        3: fault_clr = 1'b0;
        default: ;
      endcase
      exp_q.push_back(tab[i]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL conflict[%0d]: got %b expected %b", i, obs, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] e;
    logic [7:0] tab [7];
    tab = '{O_UNK, O_OPENING, O_OPENING, O_OPENING, O_OPENING, O_UNK, O_UNK};
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin rst = 1'b1; sensortop = 1'b0; end
        1: begin rst = 1'b0; cmd_up = 1'b1; end
        2: cmd_up = 1'b0;
        5: rst = 1'b1;
        6: rst = 1'b0;
        default: ;
      endcase
      exp_q.push_back(tab[i]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mid_reset[%0d]: got %b expected %b", i, obs, e);
      end
    end
  endtask

  // Stop from travel, barrier-blocked close from rest, up-wins tie, and a
  // dead-time restart on an opposite command.
  task automatic test_stop_and_restart();
    logic [7:0] e;
    logic [7:0] tab [13];
    tab = '{O_CLOSING, O_STOPPED, O_STOPPED, O_OPENING, O_DT1, O_DT1, O_DT0,
            O_DT0, O_DT1, O_DT1, O_OPENING, O_STOPPED, O_STOPPED};
    for (int i = 0; i < 13; i++) begin
      case (i)
        0:  cmd_down = 1'b1;
        1:  begin cmd_down = 1'b0; cmd_stop = 1'b1; end
        2:  begin cmd_stop = 1'b0; lightbarrier = 1'b1; cmd_down = 1'b1; end
        3:  begin lightbarrier = 1'b0; cmd_up = 1'b1; end
        4:  cmd_up = 1'b0;
        5:  cmd_down = 1'b0;
        6:  cmd_up = 1'b1;
        7:  cmd_up = 1'b0;
        11: cmd_stop = 1'b1;
        12: cmd_stop = 1'b0;
        default: ;
      endcase
      exp_q.push_back(tab[i]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stop_restart[%0d]: got %b expected %b", i, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_close_run();
    test_obstacle();
    test_watchdog();
    test_autoclose();
    test_autoclose_barrier();
    test_conflict();
    test_mid_reset();
    test_stop_and_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
